// File: rtl/conv_window_sequencer_pkg.sv
// rtl/conv_window_sequencer_pkg.sv - shared constants for the 3x3 window sequencer
// State codes, tap count, per-tap row/column offsets and stride encoding.
package conv_pkg;
  localparam int NUM_TAPS = 9;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic {STRIDE_1 = 1'b0, STRIDE_2 = 1'b1} stride_e;

  // Tap k = (dr+1)*3 + (dc+1)
  localparam int TAP_DR [NUM_TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [NUM_TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  function automatic int strideStep(input logic stride);
    return (stride == STRIDE_2) ? 2 : 1;
  endfunction
endpackage

// File: rtl/conv_window_sequencer_if.sv
// rtl/conv_window_sequencer_if.sv - source/destination RAM handshake bundle
// master = sequencer side, slave = RAM bank side.
interface conv_window_sequencer_if #(parameter int ADDR_W = 12);
  import conv_pkg::*;

  logic [NUM_TAPS*ADDR_W-1:0] addrRead;
  logic [NUM_TAPS-1:0]        tapValid;
  logic                       startRam;
  logic                       selRamD0;
  logic                       validRam;
  logic [ADDR_W-1:0]          addrWrite;
  logic                       wrEnable;

  modport master (
    output addrRead, tapValid, startRam, selRamD0, addrWrite, wrEnable,
    input  validRam
  );
  modport slave (
    input  addrRead, tapValid, startRam, selRamD0, addrWrite, wrEnable,
    output validRam
  );
endinterface

// File: rtl/conv_tap_gen.sv
// rtl/conv_tap_gen.sv - centre row/col to nine tap addresses plus in-bounds mask
// Out-of-bounds taps fall back to the centre address so the RAM never sees a wrapped read.
module conv_tap_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 7
) (
  input  logic [ROW_W-1:0]           row,
  input  logic [COL_W-1:0]           col,
  output logic [NUM_TAPS*ADDR_W-1:0] addrRead,
  output logic [NUM_TAPS-1:0]        tapValid,
  output logic [ADDR_W-1:0]          centreAddr
);
  always_comb begin
    int r, c, tr, tc;
    r          = int'(row);
    c          = int'(col);
    tr         = 0;
    tc         = 0;
    centreAddr = ADDR_W'(r * IMG_W + c);
    addrRead   = '0;
    tapValid   = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      tr = r + TAP_DR[k];
      tc = c + TAP_DC[k];
      if (tr >= 0 && tr < IMG_H && tc >= 0 && tc < IMG_W) begin
        tapValid[k]                     = 1'b1;
        addrRead[k*ADDR_W +: ADDR_W]    = ADDR_W'(tr * IMG_W + tc);
      end else begin
        addrRead[k*ADDR_W +: ADDR_W]    = centreAddr;
      end
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - 3x3 convolution address sequencer over a row-major map
// Walks centres at stride 1 or 2, issues one RAM read per centre, waits for data, strobes the write.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_opcode,
  input  logic                    i_stride,
  conv_window_sequencer_if.master ram,
  output logic                    o_busy,
  output logic                    o_finish,
  output logic [ADDR_W-1:0]       o_localAddr
);
  // One spare bit so col/row + 2 cannot wrap before the bound compare.
  localparam int ROW_W = $clog2(IMG_H) + 1;
  localparam int COL_W = $clog2(IMG_W) + 1;

  logic [2:0]        state;
  logic [ROW_W-1:0]  row, rowNext;
  logic [COL_W-1:0]  col, colNext;
  logic [ADDR_W-1:0] outIdx;
  logic              strideQ;
  logic              opcodeQ;
  logic              active;

  logic [NUM_TAPS*ADDR_W-1:0] taps;
  logic [NUM_TAPS-1:0]        mask;
  logic [ADDR_W-1:0]          centre;

  always_comb begin
    colNext = col + COL_W'(strideStep(strideQ));
    rowNext = row + ROW_W'(strideStep(strideQ));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      outIdx  <= '0;
      strideQ <= 1'b0;
      opcodeQ <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            opcodeQ <= i_opcode;
            strideQ <= i_stride;
            row     <= '0;
            col     <= '0;
            outIdx  <= '0;
            state   <= ST_READ;
          end
        end
        ST_READ:  state <= ST_WAIT;
        ST_WAIT:  if (ram.validRam) state <= ST_WRITE;
        ST_WRITE: state <= ST_UPDATE;
        ST_UPDATE: begin
          outIdx <= outIdx + 1'b1;
          if (int'(colNext) < IMG_W) begin
            col   <= colNext;
            state <= ST_READ;
          end else begin
            col   <= '0;
            row   <= rowNext;
            state <= (int'(rowNext) >= IMG_H) ? ST_DONE : ST_READ;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  conv_tap_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_tapGen (
    .row       (row),
    .col       (col),
    .addrRead  (taps),
    .tapValid  (mask),
    .centreAddr(centre)
  );

  // Window outputs are only meaningful while a centre is being processed.
  assign active = (state == ST_READ) || (state == ST_WAIT) ||
                  (state == ST_WRITE) || (state == ST_UPDATE);

  assign ram.addrRead  = active ? taps : '0;
  assign ram.tapValid  = active ? mask : '0;
  assign o_localAddr   = active ? centre : '0;
  assign ram.startRam  = (state == ST_READ);
  assign ram.wrEnable  = (state == ST_WRITE);
  assign ram.addrWrite = (state == ST_WRITE) ? outIdx : '0;
  assign ram.selRamD0  = opcodeQ;
  assign o_busy        = (state != ST_IDLE);
  assign o_finish      = (state == ST_DONE);
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - randomized self-checking bench for conv_window_sequencer
// Small 4x4 instance for scenarios, default 64x64 instance for the full-size pass.
module tb_conv_window_sequencer;
  import conv_pkg::*;

  localparam int SW = 4, SH = 4, SA = 4;
  localparam int BW = 64, BH = 64, BA = 12;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstS = 1'b0, startS = 1'b0, opcS = 1'b0, strS = 1'b0;
  logic busyS, finS;
  logic [SA-1:0] locS;
  logic rstB = 1'b0, startB = 1'b0, opcB = 1'b0, strB = 1'b0;
  logic busyB, finB;
  logic [BA-1:0] locB;

  conv_window_sequencer_if #(.ADDR_W(SA)) ramS ();
  conv_window_sequencer_if #(.ADDR_W(BA)) ramB ();

  conv_window_sequencer #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(SA)) dutS (
    .i_clk(clk), .i_reset(rstS), .i_start(startS), .i_opcode(opcS), .i_stride(strS),
    .ram(ramS), .o_busy(busyS), .o_finish(finS), .o_localAddr(locS)
  );
  conv_window_sequencer dutB (
    .i_clk(clk), .i_reset(rstB), .i_start(startB), .i_opcode(opcB), .i_stride(strB),
    .ram(ramB), .o_busy(busyB), .o_finish(finB), .o_localAddr(locB)
  );

  int tests = 0;
  int fails = 0;

  // Expected window of centre (r,c) on a WxH map, straight from the tap rules.
  function automatic void model(input int w, input int h, input int r, input int c, input int aw,
                                output logic [107:0] taps, output logic [8:0] mask);
    int k, rr, cc, a;
    taps = '0;
    mask = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        k  = (dr + 1) * 3 + (dc + 1);
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < h && cc >= 0 && cc < w) begin
          mask[k] = 1'b1;
          a = rr * w + cc;
        end else begin
          a = r * w + c;
        end
        taps = taps | (108'(a) << (k * aw));
      end
    end
  endfunction

  task automatic run_small(input logic stride, input logic opc, input int minD, input int maxD,
                           input bit poke, input int abortAt,
                           output int finAt, output int nWrites,
                           output logic [35:0] taps0, output logic [8:0] mask0,
                           output logic [35:0] taps5, output logic [8:0] mask5);
    int cr[$], cc[$];
    int n, p, cyc, d, cnt, nextRead, nextWrite, readCyc, finCycle, step;
    bit pend;
    logic [107:0] et;
    logic [8:0] em;
    step = (stride == STRIDE_2) ? 2 : 1;
    for (int r = 0; r < SH; r += step)
      for (int c = 0; c < SW; c += step) begin
        cr.push_back(r);
        cc.push_back(c);
      end
    n = cr.size();
    p = 0; cyc = 0; d = 0; cnt = 0; pend = 0;
    nextRead = 1; nextWrite = -1; readCyc = -10; finCycle = LIMIT + 10;
    et = '0; em = '0;
    taps0 = '0; mask0 = '0; taps5 = '0; mask5 = '0;
    finAt = -1; nWrites = 0;
    @(posedge clk); #1;
    startS = 1'b1; opcS = opc; strS = stride; ramS.validRam = 1'b0;
    while (cyc < finCycle && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      startS = 1'b0;
      opcS = 1'($urandom);
      strS = 1'($urandom);
      if (poke && p < n - 1 && ($urandom % 6) == 0) startS = 1'b1;
      tests++; if (ramS.startRam !== (cyc == nextRead))
        begin fails++; $display("FAIL startRam cyc=%0d got %b want %b", cyc, ramS.startRam, cyc == nextRead); end
      tests++; if (ramS.wrEnable !== (cyc == nextWrite))
        begin fails++; $display("FAIL wrEnable cyc=%0d got %b want %b", cyc, ramS.wrEnable, cyc == nextWrite); end
      tests++; if (finS !== (cyc == finCycle))
        begin fails++; $display("FAIL finish cyc=%0d got %b want %b", cyc, finS, cyc == finCycle); end
      tests++; if (busyS !== 1'b1)
        begin fails++; $display("FAIL busy cyc=%0d got %b want 1", cyc, busyS); end
      tests++; if (ramS.selRamD0 !== opc)
        begin fails++; $display("FAIL selRamD0 cyc=%0d got %b want %b", cyc, ramS.selRamD0, opc); end
      if (abortAt == p && cyc == readCyc + 1) begin
        rstS = 1'b1;
        @(posedge clk); #1;
        rstS = 1'b0;
        ramS.validRam = 1'b0;
        tests++;
        if (busyS !== 1'b0 || finS !== 1'b0 || ramS.startRam !== 1'b0 || ramS.wrEnable !== 1'b0 ||
            ramS.addrRead !== '0 || ramS.tapValid !== '0 || locS !== '0 || ramS.addrWrite !== '0 ||
            ramS.selRamD0 !== 1'b0) begin
          fails++;
          $display("FAIL abort_outputs busy=%b fin=%b start=%b wr=%b taps=%h mask=%h loc=%h aw=%h sel=%b want all 0",
                   busyS, finS, ramS.startRam, ramS.wrEnable, ramS.addrRead, ramS.tapValid, locS,
                   ramS.addrWrite, ramS.selRamD0);
        end
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          tests++;
          if (ramS.wrEnable !== 1'b0 || finS !== 1'b0 || busyS !== 1'b0 || ramS.startRam !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet i=%0d wr=%b fin=%b busy=%b start=%b want 0", i, ramS.wrEnable, finS,
                     busyS, ramS.startRam);
          end
        end
        nWrites = p;
        return;
      end
      if (cyc == nextRead) begin
        model(SW, SH, cr[p], cc[p], SA, et, em);
        tests++;
        if (ramS.addrRead !== et[35:0] || ramS.tapValid !== em || locS !== SA'(cr[p] * SW + cc[p])) begin
          fails++;
          $display("FAIL window px=%0d taps=%h want %h mask=%h want %h loc=%0d want %0d", p,
                   ramS.addrRead, et[35:0], ramS.tapValid, em, locS, cr[p] * SW + cc[p]);
        end
        if (cr[p] * SW + cc[p] == 0) begin taps0 = ramS.addrRead; mask0 = ramS.tapValid; end
        if (cr[p] * SW + cc[p] == 5) begin taps5 = ramS.addrRead; mask5 = ramS.tapValid; end
        d = $urandom_range(maxD, minD);
        readCyc = cyc;
        nextWrite = cyc + 2 + d;
        if (p + 1 < n) nextRead = cyc + 4 + d;
        else finCycle = cyc + 4 + d;
        pend = 1; cnt = d;
        ramS.validRam = 1'($urandom);
      end else if (pend) begin
        if (cnt == 0) begin ramS.validRam = 1'b1; pend = 0; end
        else begin ramS.validRam = 1'b0; cnt--; end
      end else begin
        ramS.validRam = 1'($urandom);
      end
      if (cyc == nextWrite) begin
        tests++;
        if (ramS.addrWrite !== SA'(p) || ramS.addrRead !== et[35:0] || locS !== SA'(cr[p] * SW + cc[p])) begin
          fails++;
          $display("FAIL write px=%0d addrWrite=%0d want %0d taps=%h want %h", p, ramS.addrWrite, p,
                   ramS.addrRead, et[35:0]);
        end
        p++;
      end
    end
    startS = 1'b0;
    if (cyc >= LIMIT) begin
      tests++; fails++;
      $display("FAIL timeout cyc=%0d want finish by %0d", cyc, LIMIT);
    end else begin
      finAt = cyc;
      @(posedge clk); #1;
      tests++;
      if (busyS !== 1'b0 || finS !== 1'b0 || ramS.addrRead !== '0 || ramS.tapValid !== '0 || locS !== '0) begin
        fails++;
        $display("FAIL post_done busy=%b fin=%b taps=%h mask=%h loc=%h want all 0", busyS, finS,
                 ramS.addrRead, ramS.tapValid, locS);
      end
    end
    nWrites = p;
    tests++; if (p !== n) begin fails++; $display("FAIL write_count got %0d want %0d", p, n); end
  endtask

  task automatic test_reset();
    rstS = 1'b1; rstB = 1'b1;
    startS = 1'b1; startB = 1'b1; opcS = 1'b1; opcB = 1'b1;
    ramS.validRam = 1'b1; ramB.validRam = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busyS !== 1'b0 || finS !== 1'b0 || ramS.startRam !== 1'b0 || ramS.wrEnable !== 1'b0 ||
        ramS.addrRead !== '0 || ramS.tapValid !== '0 || locS !== '0 || ramS.selRamD0 !== 1'b0 ||
        ramS.addrWrite !== '0) begin
      fails++; $display("FAIL reset_small busy=%b fin=%b start=%b sel=%b want 0", busyS, finS, ramS.startRam, ramS.selRamD0);
    end
    tests++;
    if (busyB !== 1'b0 || finB !== 1'b0 || ramB.startRam !== 1'b0 || ramB.wrEnable !== 1'b0 ||
        ramB.addrRead !== '0 || ramB.tapValid !== '0 || locB !== '0 || ramB.selRamD0 !== 1'b0) begin
      fails++; $display("FAIL reset_big busy=%b fin=%b start=%b sel=%b want 0", busyB, finB, ramB.startRam, ramB.selRamD0);
    end
    rstS = 1'b0; rstB = 1'b0;
    startS = 1'b0; startB = 1'b0; opcS = 1'b0; opcB = 1'b0;
    ramS.validRam = 1'b0; ramB.validRam = 1'b0;
  endtask

  task automatic test_stride1();
    int finAt, nw;
    int lst [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [35:0] t0, t5, e0, e5;
    logic [8:0] m0, m5;
    run_small(1'b0, 1'b1, 0, 0, 1'b0, -1, finAt, nw, t0, m0, t5, m5);
    e0 = '0; e0[5*4 +: 4] = 4'd1; e0[7*4 +: 4] = 4'd4; e0[8*4 +: 4] = 4'd5;
    e5 = '0;
    for (int k = 0; k < 9; k++) e5[k*4 +: 4] = 4'(lst[k]);
    tests++; if (t0 !== e0 || m0 !== 9'h1B0) begin fails++; $display("FAIL px00 taps=%h want %h mask=%h want 1b0", t0, e0, m0); end
    tests++; if (t5 !== e5 || m5 !== 9'h1FF) begin fails++; $display("FAIL px11 taps=%h want %h mask=%h want 1ff", t5, e5, m5); end
    tests++; if (finAt !== 65) begin fails++; $display("FAIL finish_cycle got %0d want 65", finAt); end
  endtask

  task automatic test_stride2();
    int finAt, nw;
    logic [35:0] t0, t5;
    logic [8:0] m0, m5;
    run_small(1'b1, 1'b0, 0, 0, 1'b0, -1, finAt, nw, t0, m0, t5, m5);
    tests++; if (nw !== 4 || finAt !== 17) begin fails++; $display("FAIL stride2 writes=%0d want 4 fin=%0d want 17", nw, finAt); end
  endtask

  task automatic test_wait_delay();
    int finAt, nw;
    logic [35:0] t0, t5;
    logic [8:0] m0, m5;
    run_small(1'b0, 1'b1, 3, 3, 1'b1, -1, finAt, nw, t0, m0, t5, m5);
    tests++; if (finAt !== 113) begin fails++; $display("FAIL delay3_finish got %0d want 113", finAt); end
  endtask

  task automatic test_reset_mid_pass();
    int finAt, nw;
    logic [35:0] t0, t5;
    logic [8:0] m0, m5;
    run_small(1'b0, 1'b1, 1, 3, 1'b0, 5, finAt, nw, t0, m0, t5, m5);
    tests++; if (nw !== 5) begin fails++; $display("FAIL abort_writes got %0d want 5", nw); end
    run_small(1'b0, 1'b0, 0, 2, 1'b0, -1, finAt, nw, t0, m0, t5, m5);
  endtask

  task automatic test_back_to_back();
    int finAt, nw;
    logic [35:0] t0, t5;
    logic [8:0] m0, m5;
    for (int i = 0; i < 4; i++)
      run_small(1'($urandom), 1'($urandom), 0, 4, 1'b1, -1, finAt, nw, t0, m0, t5, m5);
  endtask

  task automatic test_big();
    int cyc, writes, finAt;
    bit seen;
    logic [107:0] et;
    logic [8:0] em;
    cyc = 0; writes = 0; finAt = -1; seen = 0;
    @(posedge clk); #1;
    startB = 1'b1; strB = 1'b0; opcB = 1'b1; ramB.validRam = 1'b1;
    while (cyc < 17000 && finAt < 0) begin
      @(posedge clk); #1;
      cyc++;
      startB = 1'b0;
      if (ramB.wrEnable) begin
        tests++;
        if (ramB.addrWrite !== BA'(writes)) begin
          fails++; $display("FAIL big_write got %0d want %0d", ramB.addrWrite, writes);
        end
        writes++;
      end
      if (ramB.startRam && locB == 12'd4095) begin
        seen = 1;
        model(BW, BH, 63, 63, BA, et, em);
        tests++; if (ramB.tapValid !== 9'h01B) begin fails++; $display("FAIL big_mask got %h want 01b", ramB.tapValid); end
        tests++; if (ramB.addrRead !== et) begin fails++; $display("FAIL big_taps got %h want %h", ramB.addrRead, et); end
      end
      if (finB) finAt = cyc;
    end
    tests++; if (!seen) begin fails++; $display("FAIL big_last_pixel seen=0 want 1"); end
    tests++; if (writes !== 4096 || finAt !== 16385) begin fails++; $display("FAIL big_pass writes=%0d want 4096 fin=%0d want 16385", writes, finAt); end
    @(posedge clk); #1;
    tests++; if (finB !== 1'b0 || busyB !== 1'b0) begin fails++; $display("FAIL big_after fin=%b busy=%b want 0", finB, busyB); end
    ramB.validRam = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_wait_delay();
    test_reset_mid_pass();
    test_back_to_back();
    test_big();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
